// File: rtl/even_p_check_3bit_pkg.sv
// Shared constants for the 3-bit even-parity checker.
package even_p_check_3bit_pkg;

  localparam int unsigned DATA_W_DEFAULT = 3;
  localparam int unsigned CNT_W_DEFAULT  = 8;
  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

endpackage

// File: rtl/even_p_check_3bit_if.sv
// Data/parity inputs and check/status outputs of the parity checker.
interface even_p_check_3bit_if
  import even_p_check_3bit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) ();

  logic [DATA_W-1:0] i;
  logic              p;
  logic              pc;
  logic              pc_q;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  chk_cnt;

  modport master (
    output i,
    output p,
    input  pc,
    input  pc_q,
    input  err_sticky,
    input  err_cnt,
    input  chk_cnt
  );

  modport slave (
    input  i,
    input  p,
    output pc,
    output pc_q,
    output err_sticky,
    output err_cnt,
    output chk_cnt
  );

endinterface

// File: rtl/even_p_check_3bit_parity_xor_tree.sv
// Combinational reduction XOR; output is 1 when the word has an odd number of ones.
module parity_xor_tree #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] data_i,
  output logic             odd_o
);

  always_comb begin
    odd_o = ^data_i;
  end

endmodule

// File: rtl/even_p_check_3bit.sv
// Even-parity checker: combinational error flag plus registered copy and error statistics.
module even_p_check_3bit
  import even_p_check_3bit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  even_p_check_3bit_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             pc;
  logic             pc_q;
  logic             err_sticky_d, err_sticky_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic [CNT_W-1:0] chk_cnt_d, chk_cnt_q;

  // pc has no path through clk/rst_n so it stays valid with them unconnected.
  parity_xor_tree #(
    .Width (DATA_W + 1)
  ) u_parity_xor_tree (
    .data_i ({bus.i, bus.p}),
    .odd_o  (pc)
  );

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    chk_cnt_d    = chk_cnt_q;
    if (chk_cnt_q != CntMax) begin
      chk_cnt_d = chk_cnt_q + CNT_W'(1);
    end
    if (pc) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != CntMax) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      chk_cnt_q    <= '0;
    end else begin
      pc_q         <= pc;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      chk_cnt_q    <= chk_cnt_d;
    end
  end

  assign bus.pc         = pc;
  assign bus.pc_q       = pc_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.chk_cnt    = chk_cnt_q;

endmodule

// File: tb/tb_even_p_check_3bit.sv
// Self-checking bench for even_p_check_3bit: vector table, random model check, corner sequences.
module tb_even_p_check_3bit;
  import even_p_check_3bit_pkg::*;

  typedef struct {
    logic [2:0] i;
    logic       p;
    logic       pc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  even_p_check_3bit_if bus ();

  even_p_check_3bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Parity error means an odd count of ones across data and parity bit.
  function automatic logic ref_pc(input logic [2:0] di, input logic dp);
    return (($countones({di, dp}) % 2) == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset(input logic [2:0] di, input logic dp);
    @(negedge clk);
    rst_n  = 1'b0;
    bus.i  = di;
    bus.p  = dp;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  task automatic check_regs(input string tag, input logic pcq, input logic st,
                            input int ec, input int cc);
    check({tag, " pc_q"}, {31'd0, bus.pc_q}, {31'd0, pcq});
    check({tag, " err_sticky"}, {31'd0, bus.err_sticky}, {31'd0, st});
    check({tag, " err_cnt"}, {24'd0, bus.err_cnt}, ec);
    check({tag, " chk_cnt"}, {24'd0, bus.chk_cnt}, cc);
  endtask

  vec_t tbl[5];

  initial begin
    int m_err;
    int m_chk;
    logic m_sticky;
    logic m_pcq;
    logic exp_pc;
    logic [2:0] ri;
    logic rp;

    n_checks = 0;
    n_pass   = 0;
    tbl[0] = '{i: 3'b000, p: 1'b1, pc: 1'b1};
    tbl[1] = '{i: 3'b001, p: 1'b1, pc: 1'b0};
    tbl[2] = '{i: 3'b101, p: 1'b0, pc: 1'b0};
    tbl[3] = '{i: 3'b111, p: 1'b0, pc: 1'b1};
    tbl[4] = '{i: 3'b110, p: 1'b1, pc: 1'b1};

    rst_n = 1'b0;
    bus.i = 3'b000;
    bus.p = 1'b0;
    #1;
    check_regs("reset", 1'b0, 1'b0, 0, 0);

    // Combinational vectors, held in reset so no registers move.
    for (int k = 0; k < 5; k++) begin
      bus.i = tbl[k].i;
      bus.p = tbl[k].p;
      #1;
      check($sformatf("table pc[%0d]", k), {31'd0, bus.pc}, {31'd0, tbl[k].pc});
    end

    for (int k = 0; k < 16; k++) begin
      logic [3:0] v;
      v = k[3:0];
      bus.i = v[3:1];
      bus.p = v[0];
      #1;
      check($sformatf("exhaustive pc[%0d]", k), {31'd0, bus.pc}, {31'd0, ref_pc(v[3:1], v[0])});
    end

    // Clocked table sequence.
    do_reset(tbl[0].i, tbl[0].p);
    for (int k = 0; k < 5; k++) begin
      bus.i = tbl[k].i;
      bus.p = tbl[k].p;
      @(posedge clk);
      #1;
      check($sformatf("seq pc_q[%0d]", k), {31'd0, bus.pc_q}, {31'd0, tbl[k].pc});
      @(negedge clk);
    end
    check_regs("seq end", tbl[4].pc, 1'b1, 3, 5);

    // Random stream against a counting model.
    do_reset(3'b000, 1'b0);
    m_err = 0;
    m_chk = 0;
    m_sticky = 1'b0;
    for (int n = 0; n < 64; n++) begin
      ri = 3'($urandom_range(0, 7));
      rp = 1'($urandom_range(0, 1));
      bus.i = ri;
      bus.p = rp;
      exp_pc = ref_pc(ri, rp);
      #1;
      check("rand pc", {31'd0, bus.pc}, {31'd0, exp_pc});
      @(posedge clk);
      m_pcq = exp_pc;
      m_chk = (m_chk < int'(CNT_MAX)) ? m_chk + 1 : m_chk;
      if (exp_pc) begin
        m_err = (m_err < int'(CNT_MAX)) ? m_err + 1 : m_err;
        m_sticky = 1'b1;
      end
      #1;
      check_regs($sformatf("rand[%0d]", n), m_pcq, m_sticky, m_err, m_chk);
      @(negedge clk);
    end

    // Saturation: constant error for 300 cycles.
    do_reset(3'b000, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    check_regs("saturate", 1'b1, 1'b1, int'(CNT_MAX), int'(CNT_MAX));

    // Asynchronous reset between edges with counters non-zero.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async reset", 1'b0, 1'b0, 0, 0);
    bus.i = 3'b101;
    bus.p = 1'b1;
    #1;
    check("pc in reset a", {31'd0, bus.pc}, 32'd1);
    bus.i = 3'b011;
    bus.p = 1'b0;
    #1;
    check("pc in reset b", {31'd0, bus.pc}, 32'd0);

    // Error-free stream.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_regs("clean stream", 1'b0, 1'b0, 0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
